shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Sequencer for the team's 8-bit load/shift register datapath. It accepts parallel words over a valid/ready handshake, loads each word and shifts it out serially, left (MSB first) or right (LSB first), with a programmable bit period. While shifting out, it captures serial input into the same register and returns the received word. It sits between a parallel producer/consumer and a serial pin pair (so/si).

Parameters:
WIDTH, 8, shift register and data word width (>=2)
DIV_W, 8, width of the bit-period divider field

Ports:
clk  input  1  clock
rst  input  1  reset, synchronous, active-high
in_valid  input  1  producer has a word
in_ready  output  1  block can accept a word (IDLE only)
in_data  input  WIDTH  word to transmit
in_dir  input  1  0 = shift left/MSB first, 1 = shift right/LSB first; sampled with in_data
div  input  DIV_W  bit period = div+1 clk cycles; sampled with in_data
abort  input  1  cancel current frame
si  input  1  serial in
so  output  1  serial out
busy  output  1  high in SHIFT and DONE
done  output  1  one-cycle pulse at frame end
out_valid  output  1  one-cycle pulse, same cycle as done
out_data  output  WIDTH  received word, valid when out_valid

Behaviour:
- Reset: clk and rst are decided as above. On rst, state=IDLE, shift reg=0, counters=0, in_ready=1, so=0, busy=0, done=0, out_valid=0, out_data=0. rst has priority over every other input.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1, so=0.
  - On in_valid & in_ready: reg<=in_data, dir_q<=in_dir, div_q<=div, tick<=div, bits<=WIDTH-1; go to SHIFT.
- SHIFT:
  - so = reg[WIDTH-1] if dir_q=0, else reg[0]. so is driven combinationally from the register.
  - Each cycle: tick decrements while tick≠0.
  - When tick==0 (last cycle of the bit period), shift:
    - left: reg<={reg[WIDTH-2:0],si}
    - right: reg<={si,reg[WIDTH-1:1]}
    - then tick<=div_q.
    - If bits==0, go to DONE; else bits<=bits-1.
  - SHIFT lasts exactly WIDTH*(div_q+1) cycles.
- DONE: lasts 1 cycle. done=1, out_valid=1, out_data=reg; so=0. Next state is IDLE.
- out_data holds its value until the next DONE.
- Latency: accept edge, then WIDTH*(div+1) SHIFT cycles, then DONE. Minimum accept-to-accept spacing is WIDTH*(div+1)+2 cycles.
- Changes to div, in_dir or in_data after accept are ignored until the next accept.
- abort:
  - In SHIFT or DONE: next state IDLE, no done/out_valid pulse, out_data unchanged, reg cleared.
  - abort coincident with the DONE cycle suppresses nothing already visible: that DONE's pulses still occur, and the block returns to IDLE.
  - abort in IDLE blocks acceptance that cycle (in_ready=0 while abort=1).
- in_valid held continuously means back-to-back frames. The next accept happens in the first IDLE cycle after DONE.
- div=0 means a 1-cycle bit period. div=all-ones means a 2^DIV_W-cycle bit period. No special cases.
- No other states are reachable. Illegal state encodings return to IDLE.

Decomposition:
- Shared package shift_pkg:
  - state enum {IDLE, SHIFT, DONE}
  - DIR_LEFT=1'b0, DIR_RIGHT=1'b1
- One natural sub-module: shift_dp, the load/shift register.
  - Inputs: ld, shift, dir, si, din.
  - Output: dout.
  - Synchronous active-high rst clears it.
- shift_seq_ctrl keeps the FSM, tick/bit counters and handshake, and drives shift_dp.

Test Plan:
- WIDTH=8, div=0, in_dir=0, in_data=0x0F, si=0 → so = 0,0,0,0,1,1,1,1 on cycles 1..8 after accept; done/out_valid on cycle 9; out_data=0x00; in_ready high again on cycle 10.
- Same with in_dir=1 → so = 1,1,1,1,0,0,0,0; loopback si=so gives out_data=0x0F.
- div=3, in_dir=0, in_data=0xA5, loopback → each so bit is held 4 cycles (32 SHIFT cycles); done on cycle 33 after accept; out_data=0xA5. Changing div to 0 mid-frame has no effect.
- in_valid held high with words 0x12 then 0x34, div=0 → accepts 10 cycles apart; two done pulses; out_data=0x12 then 0x34 with loopback.
- abort asserted at SHIFT cycle 4 → IDLE next cycle; no done; out_data keeps its previous value; in_ready=1.
- rst asserted at SHIFT cycle 5, with in_valid also high → all outputs at reset values the next cycle; the frame is not resumed; the new accept occurs only after rst deasserts.

Source files
------------

// File: rtl/shift_pkg.sv
// shift_pkg: shared state and direction encodings for the shift sequencer slice.
// Rev 1.0
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

`default_nettype wire

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: parallel word handshake between producer/consumer and the sequencer.
// Rev 1.0
`default_nettype none

interface shift_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [DIV_W-1:0] div;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid, in_data, in_dir, div,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, in_dir, div,
    output in_ready, out_valid, out_data
  );

endinterface

`default_nettype wire

// File: rtl/shift_dp.sv
// shift_dp: loadable bidirectional shift register with serial input.
// Rev 1.0
`default_nettype none

module shift_dp
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             shift,
  input  logic             dir,
  input  logic             si,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] sr_d;
  logic [WIDTH-1:0] sr_q;

  always_comb begin
    sr_d = sr_q;
    if (ld) begin
      sr_d = din;
    end else if (shift) begin
      sr_d = (dir == DIR_RIGHT) ? {si, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], si};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign dout = sr_q;

endmodule

`default_nettype wire

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: frames parallel words out serially with a programmable bit period, capturing si.
// Rev 1.0
`default_nettype none

module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_seq_ctrl_if.slave       bus,
  input  logic                  abort,
  input  logic                  si,
  output logic                  so,
  output logic                  busy,
  output logic                  done
);

  localparam int BITS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SHIFT = SHIFT;
  localparam logic [1:0] ST_DONE  = DONE;

  logic [1:0]        state_d,    state_q;
  logic [DIV_W-1:0]  tick_d,     tick_q;
  logic [BITS_W-1:0] bits_d,     bits_q;
  logic              dir_d,      dir_q;
  logic [DIV_W-1:0]  div_d,      div_q;
  logic [WIDTH-1:0]  out_data_d, out_data_q;

  logic              in_ready;
  logic              accept;
  logic              dp_ld;
  logic              dp_shift;
  logic [WIDTH-1:0]  dp_din;
  logic [WIDTH-1:0]  dp_dout;

  assign in_ready = (state_q == ST_IDLE) && !abort;
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    bits_d     = bits_q;
    dir_d      = dir_q;
    div_d      = div_q;
    out_data_d = out_data_q;
    dp_ld      = 1'b0;
    dp_shift   = 1'b0;
    dp_din     = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dp_ld   = 1'b1;
          dp_din  = bus.in_data;
          dir_d   = bus.in_dir;
          div_d   = bus.div;
          tick_d  = bus.div;
          bits_d  = BITS_W'(WIDTH - 1);
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          // Loading zero clears the register without touching the shared reset.
          dp_ld   = 1'b1;
          tick_d  = '0;
          bits_d  = '0;
          state_d = ST_IDLE;
        end else if (tick_q != '0) begin
          tick_d = tick_q - DIV_W'(1);
        end else begin
          dp_shift = 1'b1;
          tick_d   = div_q;
          if (bits_q == '0) begin
            state_d = ST_DONE;
          end else begin
            bits_d = bits_q - BITS_W'(1);
          end
        end
      end
      ST_DONE: begin
        out_data_d = dp_dout;
        dp_ld      = abort;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tick_q     <= '0;
      bits_q     <= '0;
      dir_q      <= DIR_LEFT;
      div_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      bits_q     <= bits_d;
      dir_q      <= dir_d;
      div_q      <= div_d;
      out_data_q <= out_data_d;
    end
  end

  shift_dp #(
    .WIDTH (WIDTH)
  ) u_dp (
    .clk   (clk),
    .rst   (rst),
    .ld    (dp_ld),
    .shift (dp_shift),
    .dir   (dir_q),
    .si    (si),
    .din   (dp_din),
    .dout  (dp_dout)
  );

  // The DONE cycle shows the live register; afterwards the captured copy holds it.
  assign so            = (state_q == ST_SHIFT) ?
                         ((dir_q == DIR_LEFT) ? dp_dout[WIDTH-1] : dp_dout[0]) : 1'b0;
  assign busy          = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign done          = (state_q == ST_DONE);
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = done;
  assign bus.out_data  = done ? dp_dout : out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: randomized and directed frames against a bit-level frame model.
// Rev 1.0
`default_nettype none

module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int DIV_W = 8;

  logic clk;
  logic rst;
  logic abort;
  logic si_drv;
  logic loopback;
  wire  si;
  wire  so;
  wire  busy;
  wire  done;

  int n_tests = 0;
  int n_fail  = 0;
  logic [WIDTH-1:0] exp_out;

  shift_seq_ctrl_if #(.WIDTH(WIDTH), .DIV_W(DIV_W)) bus ();

  shift_seq_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .abort (abort),
    .si    (si),
    .so    (so),
    .busy  (busy),
    .done  (done)
  );

  assign si = loopback ? so : si_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete (got timeout, want finish)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // One frame: expected so is the word's bit order per direction, the received
  // word collects one si bit per bit period in arrival order.
  task automatic run_frame(input logic [WIDTH-1:0] word, input logic dir,
                           input logic [DIV_W-1:0] dv, input logic lb,
                           input logic [WIDTH-1:0] si_word, input int abort_at,
                           input logic abort_done);
    logic [WIDTH-1:0] rx;
    logic             bit_so;
    logic             bit_si;
    int               n;
    rx = '0;
    n  = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = word;
    bus.in_dir   = dir;
    bus.div      = dv;
    loopback     = lb;
    #1 check("accept_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    for (int k = 0; k < WIDTH; k++) begin
      bit_so = dir ? word[k] : word[WIDTH-1-k];
      bit_si = lb ? bit_so : si_word[k];
      if (dir) rx[k] = bit_si;
      else     rx[WIDTH-1-k] = bit_si;
      for (int c = 0; c <= int'(dv); c++) begin
        @(negedge clk);
        si_drv = si_word[k];
        if (n == 0) begin
          bus.in_valid = 1'b0;
          bus.in_data  = WIDTH'($urandom);
          bus.in_dir   = 1'($urandom);
          bus.div      = DIV_W'($urandom);
        end
        if (n == abort_at) begin
          abort = 1'b1;
          #1 check("abort_busy", 32'(busy), 32'd1);
          @(negedge clk);
          abort = 1'b0;
          #1;
          check("abort_idle", 32'(busy), 32'd0);
          check("abort_nodone", 32'(done), 32'd0);
          check("abort_ready", 32'(bus.in_ready), 32'd1);
          check("abort_hold", 32'(bus.out_data), 32'(exp_out));
          return;
        end
        #1;
        check("so", 32'(so), 32'(bit_so));
        check("busy_shift", 32'(busy), 32'd1);
        check("done_low", 32'(done), 32'd0);
        n++;
      end
    end
    @(negedge clk);
    if (abort_done) abort = 1'b1;
    #1;
    exp_out = rx;
    check("done", 32'(done), 32'd1);
    check("out_valid", 32'(bus.out_valid), 32'd1);
    check("out_data", 32'(bus.out_data), 32'(exp_out));
    check("so_done", 32'(so), 32'd0);
    check("ready_done", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("done_after", 32'(done), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ready", 32'(bus.in_ready), 32'd1);
    check("out_hold", 32'(bus.out_data), 32'(exp_out));
  endtask

  initial begin
    int acc_cyc [2];
    int n_acc;
    int n_done;
    logic prev_busy;

    rst          = 1'b1;
    abort        = 1'b0;
    si_drv       = 1'b0;
    loopback     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dir   = 1'b0;
    bus.div      = '0;
    exp_out      = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_oval", 32'(bus.out_valid), 32'd0);
    check("rst_odata", 32'(bus.out_data), 32'd0);
    check("rst_so", 32'(so), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    rst = 1'b0;

    // Directed frames from the test plan.
    run_frame(8'h0F, 1'b0, 8'd0, 1'b0, 8'h00, -1, 1'b0);
    run_frame(8'h0F, 1'b1, 8'd0, 1'b0, 8'h00, -1, 1'b0);
    run_frame(8'h0F, 1'b1, 8'd0, 1'b1, 8'h00, -1, 1'b0);
    run_frame(8'hA5, 1'b0, 8'd3, 1'b1, 8'h00, -1, 1'b0);
    run_frame(8'hC3, 1'b0, 8'd0, 1'b1, 8'h00, 4, 1'b0);
    run_frame(8'h96, 1'b1, 8'd1, 1'b0, 8'h6B, -1, 1'b1);
    run_frame(8'h81, 1'b0, 8'hFF, 1'b1, 8'h00, -1, 1'b0);

    // abort in IDLE blocks acceptance
    @(negedge clk);
    abort        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    #1 check("idle_abort_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #1 check("idle_abort_noacc", 32'(busy), 32'd0);
    abort        = 1'b0;
    bus.in_valid = 1'b0;

    // Back-to-back frames with in_valid held high.
    @(negedge clk);
    loopback     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h12;
    bus.in_dir   = 1'b0;
    bus.div      = '0;
    prev_busy    = 1'b0;
    n_acc        = 0;
    n_done       = 0;
    acc_cyc[0]   = 0;
    acc_cyc[1]   = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      #1;
      if (busy && !prev_busy && n_acc < 2) begin
        acc_cyc[n_acc] = c;
        n_acc++;
        bus.in_data = 8'h34;
        if (n_acc == 2) bus.in_valid = 1'b0;
      end
      if (done) begin
        check((n_done == 0) ? "b2b_out0" : "b2b_out1", 32'(bus.out_data),
              (n_done == 0) ? 32'h12 : 32'h34);
        n_done++;
      end
      prev_busy = busy;
    end
    check("b2b_accepts", 32'(n_acc), 32'd2);
    check("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    check("b2b_dones", 32'(n_done), 32'd2);
    exp_out      = 8'h34;
    loopback     = 1'b0;
    bus.in_valid = 1'b0;

    // Randomized frames.
    for (int i = 0; i < 16; i++) begin
      run_frame(WIDTH'($urandom), 1'($urandom), DIV_W'($urandom_range(0, 5)),
                1'($urandom), WIDTH'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1,
                1'($urandom_range(0, 4) == 0));
    end

    // rst at SHIFT cycle 5 with in_valid held high
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h5A;
    bus.in_dir   = 1'b0;
    bus.div      = '0;
    @(negedge clk);
    #1 check("rstmid_started", 32'(busy), 32'd1);
    for (int c = 0; c < 5; c++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_so", 32'(so), 32'd0);
    check("rstmid_done", 32'(done), 32'd0);
    check("rstmid_oval", 32'(bus.out_valid), 32'd0);
    check("rstmid_odata", 32'(bus.out_data), 32'd0);
    check("rstmid_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    #1 check("rstmid_noacc", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    #1 check("rstmid_reacc", 32'(busy), 32'd1);
    bus.in_valid = 1'b0;
    abort        = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    check("rstmid_abort_idle", 32'(busy), 32'd0);
    check("rstmid_abort_odata", 32'(bus.out_data), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
